branch_target_predictor: RTL and testbench
==========================================

Name: branch_target_predictor

Overview:
- Produces `next_pc` for the program counter register each cycle from the fetched `current_pc`.
- Uses a direct-mapped branch target buffer (BTB) with per-entry 2-bit saturating counters.
- Trained from EX-stage branch/jump resolution.
- A mispredict redirect from EX overrides the prediction. The block sits between the PC register output and its `next_pc` input.

Parameters:
- `BTB_IDX_BITS`, 5, log2 of BTB entry count (32 entries).
- `XLEN`, 32, address width.

Ports:
- `clk`  input  1  system clock, rising-edge.
- `reset`  input  1  asynchronous, active-low reset.
- `current_pc`  input  XLEN  PC of the instruction being fetched.
- `update_valid`  input  1  EX has resolved a control-flow instruction this cycle.
- `update_pc`  input  XLEN  PC of the resolved instruction.
- `update_taken`  input  1  resolved direction; 1 = taken.
- `update_target`  input  XLEN  resolved taken target.
- `mispredict`  input  1  EX redirect request.
- `correct_pc`  input  XLEN  redirect address, valid when `mispredict` = 1.
- `next_pc`  output  XLEN  address for the PC register to load.
- `pred_taken`  output  1  1 when `next_pc` comes from the BTB.
- `mispredict_count`  output  32  count of cycles with `mispredict` asserted.

Behaviour:
- Indexing: `idx` = pc[BTB_IDX_BITS+1:2]; `tag` = pc[XLEN-1:BTB_IDX_BITS+2]. pc[1:0] is ignored.
- Per entry storage: `valid` (1), `tag`, `target` (XLEN), `ctr` (2).
- Reset (`reset` = 0, async):
  - all `valid` = 0, all `ctr` = 2'b01, all `target` = 0, all `tag` = 0.
  - `mispredict_count` = 0.
  - `next_pc` = `current_pc`+4, `pred_taken` = 0, since no entry is valid.
  - Reset asserted mid-update discards that update.
- Lookup is combinational, zero latency:
  - hit = `valid[idx]` && `tag[idx]` == tag(`current_pc`).
  - `pred_taken` = hit && `ctr[idx]`[1] && !`mispredict`.
- `next_pc` priority:
  1. `mispredict` → `correct_pc`.
  2. `pred_taken` → `target[idx]`.
  3. otherwise `current_pc`+4, modulo 2^XLEN (0xFFFFFFFC wraps to 0x00000000).
- Update on rising `clk` edge when `update_valid` = 1, with `u` = entry `idx`(`update_pc`) and uhit = `valid[u]` && tag match:
  - taken, uhit: `target[u]` ← `update_target`; `ctr[u]` ← min(`ctr`+1, 3).
  - taken, !uhit (allocate or replace): `valid` ← 1, `tag` ← tag(`update_pc`), `target` ← `update_target`, `ctr` ← 2'b10 (weakly taken).
  - not taken, uhit: `ctr[u]` ← max(`ctr`−1, 0); entry stays valid with target unchanged.
  - not taken, !uhit: no state change; no allocation.
- No write-to-read bypass: a lookup in the same cycle as an update to the same index sees the pre-update contents. The new contents are visible from the next cycle.
- `update_valid` and `mispredict` are independent. Both may act in the same cycle: the redirect drives `next_pc` while the update writes the BTB.
- `mispredict_count` increments by 1 on each rising edge with `mispredict` = 1 and wraps from 0xFFFFFFFF to 0.
- No stall input. The PC register holds its own value on stall, and `next_pc` remains a pure function of the current inputs and BTB state.
- Only one update per cycle. Inputs are assumed synchronous to `clk`.

Test Plan:
1. Reset then release, `current_pc`=0x100, no updates → `next_pc`=0x104, `pred_taken`=0, `mispredict_count`=0. Also `current_pc`=0xFFFFFFFC → `next_pc`=0x0.
2. Single taken update (`update_pc`=0x100, `update_target`=0x200, taken), then `current_pc`=0x100 next cycle → `next_pc`=0x200, `pred_taken`=1.
3. Counter training at 0x100:
   - after the step 2 allocation: not taken ×1 → `ctr`=1, `next_pc`=0x104.
   - taken ×1 → `ctr`=2, `next_pc`=0x200.
   - taken ×3 → `ctr` saturates at 3.
   - not taken ×4 → `ctr`=0 with no underflow.
4. Alias replacement:
   - train 0x100→0x200; `update_pc`=0x180 lands on the same index with a different tag, taken to 0x300.
   - `current_pc`=0x100 → `next_pc`=0x104; `current_pc`=0x180 → `next_pc`=0x300.
   - not-taken update at 0x1100 (same index, different tag from the 0x180 entry, no hit) → entry unchanged.
5. Same-cycle update and lookup of 0x100 on an empty BTB → that cycle `next_pc`=0x104; next cycle `next_pc`=0x200.
6. `mispredict`=1 with `correct_pc`=0x400 while `current_pc` hits the BTB → `next_pc`=0x400, `pred_taken`=0, `mispredict_count` increments by 1. Assert `reset` low asynchronously mid-cycle → `valid` cleared immediately, `next_pc`=`current_pc`+4, counter=0.

Source files
------------

// File: rtl/branch_target_predictor_if.sv
// Fetch-side lookup and EX-side resolution signals of the branch target predictor.
// master = pipeline (PC register / EX stage), slave = predictor.
interface branch_target_predictor_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] current_pc;
  logic            update_valid;
  logic [XLEN-1:0] update_pc;
  logic            update_taken;
  logic [XLEN-1:0] update_target;
  logic            mispredict;
  logic [XLEN-1:0] correct_pc;
  logic [XLEN-1:0] next_pc;
  logic            pred_taken;
  logic [31:0]     mispredict_count;

  modport master (
    output current_pc, update_valid, update_pc, update_taken, update_target,
           mispredict, correct_pc,
    input  next_pc, pred_taken, mispredict_count
  );

  modport slave (
    input  current_pc, update_valid, update_pc, update_taken, update_target,
           mispredict, correct_pc,
    output next_pc, pred_taken, mispredict_count
  );
endinterface

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters; produces next_pc each cycle,
// trained from EX resolution, overridden by EX mispredict redirect.
module btp_entry #(
  parameter int TAG_W = 25,
  parameter int XLEN  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             upd_en,
  input  logic [TAG_W-1:0] upd_tag,
  input  logic             upd_taken,
  input  logic [XLEN-1:0]  upd_target,
  output logic             valid,
  output logic [TAG_W-1:0] tag,
  output logic [XLEN-1:0]  target,
  output logic [1:0]       ctr
);
  logic uhit;
  assign uhit = valid && (tag == upd_tag);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid  <= 1'b0;
      tag    <= '0;
      target <= '0;
      ctr    <= 2'b01;
    end else if (upd_en) begin
      if (upd_taken) begin
        target <= upd_target;
        if (uhit) begin
          if (ctr != 2'b11) ctr <= ctr + 2'b01;
        end else begin
          // allocate or replace an aliasing entry, starting weakly taken
          valid <= 1'b1;
          tag   <= upd_tag;
          ctr   <= 2'b10;
        end
      end else if (uhit && ctr != 2'b00) begin
        ctr <= ctr - 2'b01;
      end
    end
  end
endmodule

module branch_target_predictor #(
  parameter int BTB_IDX_BITS = 5,
  parameter int XLEN         = 32
) (
  input logic                      clk,
  input logic                      reset,
  branch_target_predictor_if.slave bus
);
  localparam int ENTRIES = 1 << BTB_IDX_BITS;
  localparam int TAG_W   = XLEN - BTB_IDX_BITS - 2;

  logic [BTB_IDX_BITS-1:0] idx, uidx;
  logic [TAG_W-1:0]        tag, utag;

  logic [ENTRIES-1:0]                e_valid;
  logic [ENTRIES-1:0][TAG_W-1:0]     e_tag;
  logic [ENTRIES-1:0][XLEN-1:0]      e_target;
  logic [ENTRIES-1:0][1:0]           e_ctr;

  logic            hit, pred_taken;
  logic [XLEN-1:0] next_pc;
  logic [31:0]     mp_cnt;
  logic            unused_pc_bits;

  assign idx  = bus.current_pc[BTB_IDX_BITS+1:2];
  assign tag  = bus.current_pc[XLEN-1:BTB_IDX_BITS+2];
  assign uidx = bus.update_pc[BTB_IDX_BITS+1:2];
  assign utag = bus.update_pc[XLEN-1:BTB_IDX_BITS+2];
  assign unused_pc_bits = ^{bus.current_pc[1:0], bus.update_pc[1:0]};

  for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
    btp_entry #(.TAG_W(TAG_W), .XLEN(XLEN)) u_entry (
      .clk        (clk),
      .reset      (reset),
      .upd_en     (bus.update_valid && (uidx == BTB_IDX_BITS'(i))),
      .upd_tag    (utag),
      .upd_taken  (bus.update_taken),
      .upd_target (bus.update_target),
      .valid      (e_valid[i]),
      .tag        (e_tag[i]),
      .target     (e_target[i]),
      .ctr        (e_ctr[i])
    );
  end

  // lookup reads registered entry state, so a same-cycle update is not bypassed
  assign hit = e_valid[idx] && (e_tag[idx] == tag);

  always_comb begin
    pred_taken = hit && e_ctr[idx][1] && !bus.mispredict;
    next_pc    = bus.current_pc + XLEN'(4);
    if (bus.mispredict)  next_pc = bus.correct_pc;
    else if (pred_taken) next_pc = e_target[idx];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              mp_cnt <= '0;
    else if (bus.mispredict) mp_cnt <= mp_cnt + 32'd1;
  end

  assign bus.next_pc          = next_pc;
  assign bus.pred_taken       = pred_taken;
  assign bus.mispredict_count = mp_cnt;
endmodule

// File: tb/tb_branch_target_predictor.sv
// Scoreboarded directed test of branch_target_predictor: stimulus queues
// hand-computed expectations, a negedge monitor pops and compares them.
module tb_branch_target_predictor;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  branch_target_predictor_if #(.XLEN(XLEN)) bus ();

  branch_target_predictor #(.BTB_IDX_BITS(5), .XLEN(XLEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    logic [31:0] npc;
    logic        pt;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // monitor: output is combinational, so an expectation is valid for the whole cycle
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({e.name, ".next_pc"}, bus.next_pc, e.npc);
      chk({e.name, ".pred_taken"}, {31'd0, bus.pred_taken}, {31'd0, e.pt});
      chk({e.name, ".mp_count"}, bus.mispredict_count, e.cnt);
    end
  end

  task automatic drive(input string nm, input logic [31:0] cpc,
                       input logic uv, input logic [31:0] upc, input logic ut,
                       input logic [31:0] utgt, input logic mp, input logic [31:0] cor,
                       input logic [31:0] enpc, input logic ept, input logic [31:0] ecnt);
    bus.current_pc    = cpc;
    bus.update_valid  = uv;
    bus.update_pc     = upc;
    bus.update_taken  = ut;
    bus.update_target = utgt;
    bus.mispredict    = mp;
    bus.correct_pc    = cor;
    q.push_back('{nm, enpc, ept, ecnt});
    @(posedge clk); #1;
  endtask

  task automatic look(input string nm, input logic [31:0] cpc,
                      input logic [31:0] enpc, input logic ept);
    drive(nm, cpc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, enpc, ept, 32'd0);
  endtask

  task automatic lookupd(input string nm, input logic [31:0] cpc, input logic [31:0] upc,
                         input logic ut, input logic [31:0] utgt,
                         input logic [31:0] enpc, input logic ept);
    drive(nm, cpc, 1'b1, upc, ut, utgt, 1'b0, 32'h0, enpc, ept, 32'd0);
  endtask

  initial begin
    bus.current_pc = 32'h100; bus.update_valid = 1'b0; bus.update_pc = 32'h0;
    bus.update_taken = 1'b0; bus.update_target = 32'h0; bus.mispredict = 1'b0;
    bus.correct_pc = 32'h0;
    @(posedge clk); #1;
    // 1: reset state and sequential fallthrough
    look("rst_hold", 32'h100, 32'h104, 1'b0);
    reset = 1'b1;
    look("t1_seq", 32'h100, 32'h104, 1'b0);
    look("t1_wrap", 32'hFFFF_FFFC, 32'h0, 1'b0);
    // 2: allocate 0x100 -> 0x200 (ctr=2)
    lookupd("t2_alloc", 32'h40, 32'h100, 1'b1, 32'h200, 32'h44, 1'b0);
    look("t2_hit", 32'h100, 32'h200, 1'b1);
    // 3: counter training; each lookup sees the pre-update counter
    lookupd("t3_nt1", 32'h100, 32'h100, 1'b0, 32'h0, 32'h200, 1'b1);   // 2->1
    lookupd("t3_t1", 32'h100, 32'h100, 1'b1, 32'h200, 32'h104, 1'b0);  // 1->2
    lookupd("t3_t2", 32'h100, 32'h100, 1'b1, 32'h200, 32'h200, 1'b1);  // 2->3
    lookupd("t3_t3", 32'h100, 32'h100, 1'b1, 32'h200, 32'h200, 1'b1);  // 3->3
    lookupd("t3_t4", 32'h100, 32'h100, 1'b1, 32'h200, 32'h200, 1'b1);  // 3->3
    lookupd("t3_nt2", 32'h100, 32'h100, 1'b0, 32'h0, 32'h200, 1'b1);   // 3->2
    lookupd("t3_nt3", 32'h100, 32'h100, 1'b0, 32'h0, 32'h200, 1'b1);   // 2->1
    lookupd("t3_nt4", 32'h100, 32'h100, 1'b0, 32'h0, 32'h104, 1'b0);   // 1->0
    lookupd("t3_nt5", 32'h100, 32'h100, 1'b0, 32'h0, 32'h104, 1'b0);   // 0->0
    lookupd("t3_t5", 32'h100, 32'h100, 1'b1, 32'h200, 32'h104, 1'b0);  // 0->1
    lookupd("t3_t6", 32'h100, 32'h100, 1'b1, 32'h200, 32'h104, 1'b0);  // 1->2
    look("t3_final", 32'h100, 32'h200, 1'b1);
    // 4: alias 0x180 replaces 0x100 at index 0
    lookupd("t4_repl", 32'h40, 32'h180, 1'b1, 32'h300, 32'h44, 1'b0);
    look("t4_old", 32'h100, 32'h104, 1'b0);
    look("t4_new", 32'h180, 32'h300, 1'b1);
    lookupd("t4_nt_miss", 32'h180, 32'h1100, 1'b0, 32'h0, 32'h300, 1'b1);
    look("t4_kept", 32'h180, 32'h300, 1'b1);
    look("t4_1100", 32'h1100, 32'h1104, 1'b0);
    // 5: empty BTB, same-cycle update and lookup
    reset = 1'b0;
    look("t5_rst", 32'h180, 32'h184, 1'b0);
    reset = 1'b1;
    look("t5_cleared", 32'h180, 32'h184, 1'b0);
    lookupd("t5_same", 32'h100, 32'h100, 1'b1, 32'h200, 32'h104, 1'b0);
    look("t5_next", 32'h100, 32'h200, 1'b1);
    // 6: redirect beats a hit; redirect concurrent with an update
    drive("t6_mp", 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h400, 32'h400, 1'b0, 32'd0);
    drive("t6_after", 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h200, 1'b1, 32'd1);
    drive("t6_mp_upd", 32'h40, 1'b1, 32'h140, 1'b1, 32'h600, 1'b1, 32'h500, 32'h500, 1'b0, 32'd1);
    drive("t6_upd_hit", 32'h140, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h600, 1'b1, 32'd2);
    // async reset mid-cycle, with an in-flight update that must be discarded
    reset = 1'b0;
    drive("t6_async", 32'h140, 1'b1, 32'h100, 1'b1, 32'h700, 1'b0, 32'h0, 32'h144, 1'b0, 32'd0);
    reset = 1'b1;
    look("t6_post_100", 32'h100, 32'h104, 1'b0);
    look("t6_post_140", 32'h140, 32'h144, 1'b0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
